video_driver: RTL

Timing generator for the HDMI output path, defaults 1280x720@60 (74.25 MHz pixel clock). Produces sync, data-enable and pixel-coordinate requests for the downstream `video_display` pattern stage. It also takes back that stage's `pixel_data` (registered, 1-cycle latency) and emits blanked RGB to the TMDS encoder alongside `video_hs`/`video_vs`/`video_de`.

---
 rtl/video_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/video_driver.sv
// Raster timing generator for the HDMI path: free-running line/frame counters,
// registered sync/enable/coordinate decode, and blanked RGB pass-through.
module video_driver #(
    parameter logic [10:0] H_SYNC   = 11'd40,
    parameter logic [10:0] H_BACK   = 11'd220,
    parameter logic [10:0] H_DISP   = 11'd1280,
    parameter logic [10:0] H_FRONT  = 11'd110,
    parameter logic [10:0] H_TOTAL  = 11'd1650,
    parameter logic [10:0] V_SYNC   = 11'd5,
    parameter logic [10:0] V_BACK   = 11'd20,
    parameter logic [10:0] V_DISP   = 11'd720,
    parameter logic [10:0] V_FRONT  = 11'd5,
    parameter logic [10:0] V_TOTAL  = 11'd750,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start
);
    localparam logic [10:0] HA = H_SYNC + H_BACK;
    localparam logic [10:0] VA = V_SYNC + V_BACK;

    logic [10:0] cnt_h;
    logic [10:0] cnt_v;
    logic        end_line;

    assign end_line = (cnt_h == H_TOTAL - 11'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (end_line) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_TOTAL - 11'd1) ? 11'd0 : cnt_v + 11'd1;
        end else begin
            cnt_h <= cnt_h + 11'd1;
        end
    end

    logic        v_act;
    logic        hs_d;
    logic        vs_d;
    logic        de_d;
    logic        req_d;
    logic        fs_d;
    logic [10:0] xpos_d;
    logic [10:0] ypos_d;

    // NOTE: every signal gets a value on every path (coordinate defaults come
    // first) so this block never infers a latch.
    always_comb begin
        xpos_d = '0;
        ypos_d = '0;
        v_act  = (cnt_v >= VA) && (cnt_v < VA + V_DISP);
        hs_d   = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
        de_d   = v_act && (cnt_h >= HA) && (cnt_h < HA + H_DISP);
        req_d  = v_act && (cnt_h >= HA - 11'd1) && (cnt_h < HA + H_DISP - 11'd1);
        fs_d   = (cnt_h == 11'd0) && (cnt_v == 11'd0);
        if (req_d) begin
            xpos_d = cnt_h - (HA - 11'd1);
            ypos_d = cnt_v - VA;
        end
    end

    // Outputs present the counter position of the previous cycle, all together.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= ~SYNC_POL;
            video_vs    <= ~SYNC_POL;
            video_de    <= 1'b0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= hs_d;
            video_vs    <= vs_d;
            video_de    <= de_d;
            data_req    <= req_d;
            pixel_xpos  <= xpos_d;
            pixel_ypos  <= ypos_d;
            frame_start <= fs_d;
        end
    end

    // Downstream answers a request one cycle later, exactly while de is high.
    assign video_rgb = video_de ? pixel_data : 24'd0;

endmodule
